// File: rtl/alu_pkg.sv
// Shared ALU control definitions: control codes, ALUOp encodings, R-type
// opcode fields and the issue FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_NOR   = 2'b11;

  localparam logic [10:0] OPF_ADD = 11'b10001011000;
  localparam logic [10:0] OPF_SUB = 11'b11001011000;
  localparam logic [10:0] OPF_AND = 11'b10001010000;
  localparam logic [10:0] OPF_ORR = 11'b10101010000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: ALUOp plus opcode field to 4-bit ALU code.
// Unsupported R-type fields fall back to ADD and raise the illegal flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0]  aluop,
  input  logic [10:0] opfield,
  output logic [3:0]  code,
  output logic        illegal
);

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_LDST: code = ALU_ADD;
      ALUOP_CBZ:  code = ALU_PASSB;
      ALUOP_NOR:  code = ALU_NOR;
      default: begin
        case (opfield)
          OPF_ADD: code = ALU_ADD;
          OPF_SUB: code = ALU_SUB;
          OPF_AND: code = ALU_AND;
          OPF_ORR: code = ALU_ORR;
          default: begin
            code    = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/control stage for the external 64-bit ALU: registers operands and
// control code, then captures and holds the ALU result for the consumer.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [10:0]      in_opfield,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  issue_state_e     state_q, state_d;
  logic [N-1:0]     alu_a_q, alu_a_d;
  logic [N-1:0]     alu_b_q, alu_b_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic             pend_illegal_q, pend_illegal_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_zero_q, out_zero_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

  logic [3:0] dec_code;
  logic       dec_illegal;
  logic       load;

  alu_ctrl_decode u_decode (
    .aluop   (in_aluop),
    .opfield (in_opfield),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d         = state_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_opcode_d    = alu_opcode_q;
    pend_illegal_d  = pend_illegal_q;
    out_data_d      = out_data_q;
    out_zero_d      = out_zero_q;
    out_illegal_d   = out_illegal_q;
    illegal_count_d = illegal_count_q;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    load            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU has had one full cycle on the registered operands
        out_data_d    = alu_result;
        out_zero_d    = alu_zero;
        out_illegal_d = pend_illegal_q;
        if (pend_illegal_q) illegal_count_d = sat_inc(illegal_count_q);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      alu_a_d        = in_a;
      alu_b_d        = in_b;
      alu_opcode_d   = dec_code;
      pend_illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_opcode_q    <= 4'b0000;
      pend_illegal_q  <= 1'b0;
      out_data_q      <= '0;
      out_zero_q      <= 1'b0;
      out_illegal_q   <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      state_q         <= state_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_opcode_q    <= alu_opcode_d;
      pend_illegal_q  <= pend_illegal_d;
      out_data_q      <= out_data_d;
      out_zero_q      <= out_zero_d;
      out_illegal_q   <= out_illegal_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_opcode    = alu_opcode_q;
  assign out_data      = out_data_q;
  assign out_zero      = out_zero_q;
  assign out_illegal   = out_illegal_q;
  assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU on the alu_* side
// and a reference model of decode, result and illegal counting.
module tb_alu_issue_ctrl;

  localparam int N     = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [10:0]      in_opfield;
  logic [N-1:0]     in_a, in_b;
  logic [N-1:0]     alu_a, alu_b;
  logic [3:0]       alu_opcode;
  logic [N-1:0]     alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_zero;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_opfield(in_opfield), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  // External ALU stand-in, driven by the DUT's registered controls
  always_comb begin
    case (alu_opcode)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what the instruction means, then what it computes
  task automatic ref_op(input logic [1:0] op, input logic [10:0] opf,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [3:0] code, output logic ill,
                        output logic [63:0] res);
    ill = 1'b0;
    if (op == 2'b00)      begin code = 4'b0010; res = a + b; end
    else if (op == 2'b01) begin code = 4'b0111; res = b; end
    else if (op == 2'b11) begin code = 4'b1100; res = ~(a | b); end
    else if (opf == 11'b10001011000) begin code = 4'b0010; res = a + b; end
    else if (opf == 11'b11001011000) begin code = 4'b0110; res = a - b; end
    else if (opf == 11'b10001010000) begin code = 4'b0000; res = a & b; end
    else if (opf == 11'b10101010000) begin code = 4'b0001; res = a | b; end
    else begin code = 4'b0010; ill = 1'b1; res = a + b; end
  endtask

  // Called at a negedge; returns at the negedge where the result is presented.
  task automatic issue(input logic [1:0] op, input logic [10:0] opf,
                       input logic [63:0] a, input logic [63:0] b);
    logic [3:0]  ec;
    logic        eil;
    logic [63:0] er;
    int n;
    ref_op(op, opf, a, b, ec, eil, er);
    in_valid = 1'b1; in_aluop = op; in_opfield = opf; in_a = a; in_b = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check("accept_wait", 64'(n < 20), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("exec_opcode", 64'(alu_opcode), 64'(ec));
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_out_valid", 64'(out_valid), 64'd0);
    check("exec_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    if (eil && model_cnt < 255) model_cnt++;
    check("hold_out_valid", 64'(out_valid), 64'd1);
    check("hold_out_data", out_data, er);
    check("hold_out_zero", 64'(out_zero), 64'(er == 64'd0));
    check("hold_out_illegal", 64'(out_illegal), 64'(eil));
    check("hold_illegal_count", 64'(illegal_count), 64'(model_cnt));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_alu_a"}, alu_a, 64'd0);
    check({tag, "_alu_b"}, alu_b, 64'd0);
    check({tag, "_opcode"}, 64'(alu_opcode), 64'd0);
    check({tag, "_out_data"}, out_data, 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_zero"}, 64'(out_zero), 64'd0);
    check({tag, "_out_illegal"}, 64'(out_illegal), 64'd0);
    check({tag, "_count"}, 64'(illegal_count), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [10:0] legal_opf [4];
    logic [63:0] held;
    logic [1:0]  rop;
    logic [10:0] ropf;
    logic [63:0] ra, rb;
    int stall;
    legal_opf[0] = 11'b10001011000; legal_opf[1] = 11'b11001011000;
    legal_opf[2] = 11'b10001010000; legal_opf[3] = 11'b10101010000;

    rst = 1'b1; in_valid = 1'b0; in_aluop = 2'b00; in_opfield = '0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    issue(2'b10, 11'b10001011000, 64'd5, 64'd7);
    issue(2'b10, 11'b11001011000, 64'h1234, 64'h1234);
    issue(2'b01, 11'd0, 64'd3, 64'd0);
    issue(2'b01, 11'd0, 64'd3, 64'd9);
    issue(2'b00, 11'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    issue(2'b11, 11'd0, 64'hF0F0, 64'h0F0F);
    issue(2'b10, 11'b10001010000, 64'hFF00, 64'h0FF0);
    issue(2'b10, 11'b10101010000, 64'hFF00, 64'h0FF0);
    issue(2'b10, 11'b11111111111, 64'd2, 64'd3);

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", out_data, held);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    issue(2'b10, 11'b10001011000, 64'd100, 64'd23);

    // Randomized ops with occasional stalls in HOLD
    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ropf = ($urandom_range(0, 3) == 0) ? 11'($urandom) : legal_opf[$urandom_range(0, 3)];
      ra   = {$urandom, $urandom};
      rb   = ($urandom_range(0, 4) == 0) ? ra : {$urandom, $urandom};
      issue(rop, ropf, ra, rb);
      stall = $urandom_range(0, 2);
      if (stall > 0) begin
        out_ready = 1'b0;
        held = out_data;
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); @(negedge clk);
          check("rnd_stall_data", out_data, held);
          check("rnd_stall_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); @(negedge clk);
        check("rnd_idle_valid", 64'(out_valid), 64'd0);
        check("rnd_idle_ready", 64'(in_ready), 64'd1);
      end
    end

    // Saturation of the illegal counter
    while (model_cnt < 255) issue(2'b10, 11'b11111111111, 64'd1, 64'd1);
    for (int i = 0; i < 3; i++) issue(2'b10, 11'b00000000000, 64'd1, 64'd1);
    check("sat_count", 64'(illegal_count), 64'd255);

    // Reset while in EXEC discards the pending result
    @(posedge clk); @(negedge clk);
    in_valid = 1'b1; in_aluop = 2'b10; in_opfield = 11'b10001011000;
    in_a = 64'd40; in_b = 64'd2;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_opcode", 64'(alu_opcode), 64'd2);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    check_reset_state("rst_exec");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_no_pulse", 64'(out_valid), 64'd0);
    end

    issue(2'b10, 11'b10001011000, 64'd5, 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
